// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART ASCII command parsers: FSM encoding,
// character constants and the ASCII-to-nibble helper.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_TERM,
        ST_ISSUE,
        ST_ERR
    } state_e;

    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_r  = 8'h72;
    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_Q  = 8'h3F;

    // Returns {is_hex, nib}; nib is 0 when the byte is not a hex digit.
    function automatic logic [4:0] hex_to_nib(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'b0;
        if (ch >= 8'h30 && ch <= 8'h39)
            r = {1'b1, 4'(ch - 8'h30)};
        else if (ch >= 8'h41 && ch <= 8'h46)
            r = {1'b1, 4'(ch - 8'h37)};
        else if (ch >= 8'h61 && ch <= 8'h66)
            r = {1'b1, 4'(ch - 8'h57)};
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_hex.sv
// Combinational ASCII hex digit decoder, shared with the write-command parser.
module ascii_hex_decode
    import uart_cmd_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic       is_hex_o,
    output logic [3:0] nib_o
);

    assign {is_hex_o, nib_o} = hex_to_nib(ch_i);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "R<addr hex><len hex><CR>" lines from uart_rx into {addr,len} commands.
// Optional byte echo to uart_tx is enabled with `define UART_CMD_PARSER_ECHO_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_DIGITS = 6,
    parameter int         LEN_DIGITS  = 2,
    parameter logic [7:0] TERM_CHAR   = 8'h0D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     rx_read,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [4*ADDR_DIGITS-1:0] cmd_addr,
    output logic [4*LEN_DIGITS:0]    cmd_len,
    output logic                     cmd_err,
    output logic [7:0]               echo_data,
    output logic                     echo_write,
    input  logic                     echo_ready
);

    localparam int AW = 4 * ADDR_DIGITS;
    localparam int LW = 4 * LEN_DIGITS;
    localparam int CW = $clog2(ADDR_DIGITS + LEN_DIGITS + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   len_q, len_d;
    logic            rx_read_q, err_q, err_d;
    logic            consume, echo_ok, is_hex, is_term;
    logic [3:0]      nib;

    ascii_hex_decode u_hex (
        .ch_i     (rx_data),
        .is_hex_o (is_hex),
        .nib_o    (nib)
    );

    assign is_term = (rx_data == TERM_CHAR);
    // The !rx_read_q term stops a byte being taken twice while uart_rx drops rx_valid.
    assign consume = rx_valid && !rx_read_q && (state_q != ST_ISSUE) && echo_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = 1'b0;
        if (consume) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == CHAR_R || rx_data == CHAR_r) begin
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                        addr_d  = '0;
                        len_d   = '0;
                    end else if (!(is_term || rx_data == CHAR_SP || rx_data == CHAR_LF)) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                ST_ADDR: begin
                    if (is_hex) begin
                        addr_d = {addr_q[AW-5:0], nib};
                        if (cnt_q == CW'(ADDR_DIGITS - 1)) begin
                            state_d = ST_LEN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = is_term ? ST_IDLE : ST_ERR;
                    end
                end
                ST_LEN: begin
                    if (is_hex) begin
                        len_d = {len_q[LW-5:0], nib};
                        if (cnt_q == CW'(LEN_DIGITS - 1)) begin
                            state_d = ST_TERM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = is_term ? ST_IDLE : ST_ERR;
                    end
                end
                ST_TERM: begin
                    if (is_term) begin
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (is_term)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_q == ST_ISSUE && cmd_ready)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rx_read_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rx_read_q <= consume;
            err_q     <= err_d;
        end
    end

    assign rx_read   = rx_read_q;
    assign cmd_err   = err_q;
    assign cmd_valid = (state_q == ST_ISSUE);
    assign cmd_addr  = cmd_valid ? addr_q : '0;
    // A length field of all zeros encodes the maximum burst.
    assign cmd_len   = !cmd_valid      ? '0 :
                       (len_q == '0)   ? {1'b1, {LW{1'b0}}} : {1'b0, len_q};

`ifdef UART_CMD_PARSER_ECHO_EN
    logic       echo_write_q, pend_q;
    logic [7:0] echo_data_q;

    // pend_q holds the '?' owed after a malformed byte; it blocks intake until sent.
    assign echo_ok = echo_ready && !echo_write_q && !pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_write_q <= 1'b0;
            echo_data_q  <= '0;
            pend_q       <= 1'b0;
        end else begin
            echo_write_q <= 1'b0;
            if (consume) begin
                echo_write_q <= 1'b1;
                echo_data_q  <= rx_data;
                pend_q       <= err_d;
            end else if (pend_q && echo_ready && !echo_write_q) begin
                echo_write_q <= 1'b1;
                echo_data_q  <= CHAR_Q;
                pend_q       <= 1'b0;
            end
        end
    end

    assign echo_write = echo_write_q;
    assign echo_data  = echo_data_q;
`else
    // echo_ready is referenced only so the port is not flagged as dangling.
    assign echo_ok    = echo_ready | 1'b1;
    assign echo_write = 1'b0;
    assign echo_data  = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: parsing, backpressure, errors, reset, echo.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_read;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        cmd_err;
    logic [7:0]  echo_data;
    logic        echo_write;
    logic        echo_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    int          acc_cnt = 0;
    int          err_cnt = 0;
    int          rd_cnt  = 0;
    int          echo_cnt = 0;
    logic [23:0] last_addr = '0;
    logic [8:0]  last_len  = '0;
    logic [7:0]  echo_q[$];

    uart_cmd_parser dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_read    (rx_read),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_err    (cmd_err),
        .echo_data  (echo_data),
        .echo_write (echo_write),
        .echo_ready (echo_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            last_addr = cmd_addr;
            last_len  = cmd_len;
        end
        if (cmd_err)    err_cnt++;
        if (rx_read)    rd_cnt++;
        if (echo_write) begin
            echo_cnt++;
            echo_q.push_back(echo_data);
        end
    end

    // uart_rx model: rx_valid stays up for 1+extra cycles counted from the pop.
    task automatic send_byte(input logic [7:0] b, input int extra);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_read !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL pop_timeout byte=%02h got=no rx_read want=rx_read", b);
        end
        repeat (extra) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s, input int extra);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], extra);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_valid, cmd_err, rx_read, echo_write, cmd_addr, cmd_len, echo_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b e=%b r=%b a=%h l=%h want all 0",
                     cmd_valid, cmd_err, rx_read, cmd_addr, cmd_len);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (cmd_valid !== 1'b0 || rx_read !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got v=%b r=%b want 0 0", cmd_valid, rx_read);
        end
    endtask

    task automatic test_basic;
        int a0, e0;
        a0 = acc_cnt;
        e0 = err_cnt;
        cmd_ready = 1'b1;
        send_str("R4000001A", 0);
        rx_data  = 8'h0D;
        rx_valid = 1'b1;
        for (int n = 0; n < 50 && rx_read !== 1'b1; n++) @(negedge clk);
        total++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 24'h400000 || cmd_len !== 9'd26) begin
            bad++;
            $display("FAIL basic_issue got v=%b a=%h l=%0d want v=1 a=400000 l=26",
                     cmd_valid, cmd_addr, cmd_len);
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (acc_cnt - a0 != 1) begin
            bad++;
            $display("FAIL basic_accepts got=%0d want=1", acc_cnt - a0);
        end
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid_drop got=%b want=0", cmd_valid);
        end
        total++;
        if (err_cnt != e0) begin
            bad++;
            $display("FAIL basic_no_err got=%0d want=0", err_cnt - e0);
        end
    endtask

    task automatic test_backpressure;
        int a0, r0, held_bad;
        a0 = acc_cnt;
        held_bad = 0;
        cmd_ready = 1'b0;
        send_str("r40abcd00\r", 0);
        r0 = rd_cnt;
        rx_data  = "R";
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_addr !== 24'h40ABCD || cmd_len !== 9'd256
                || rx_read !== 1'b0)
                held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL hold_stable got=%0d bad cycles (v=%b a=%h l=%0d) want=0",
                     held_bad, cmd_valid, cmd_addr, cmd_len);
        end
        total++;
        if (rd_cnt != r0 || acc_cnt != a0) begin
            bad++;
            $display("FAIL hold_no_pop got pops=%0d acc=%0d want 0 0", rd_cnt - r0, acc_cnt - a0);
        end
        cmd_ready = 1'b1;
        send_byte("R", 0);
        total++;
        if (acc_cnt - a0 != 1 || last_len !== 9'd256 || last_addr !== 24'h40ABCD) begin
            bad++;
            $display("FAIL hold_accept got n=%0d a=%h l=%0d want n=1 a=40abcd l=256",
                     acc_cnt - a0, last_addr, last_len);
        end
        send_str("ABCDEF01\r", 0);
        repeat (2) @(negedge clk);
        total++;
        if (acc_cnt - a0 != 2 || last_addr !== 24'hABCDEF || last_len !== 9'd1) begin
            bad++;
            $display("FAIL next_line got n=%0d a=%h l=%0d want n=2 a=abcdef l=1",
                     acc_cnt - a0, last_addr, last_len);
        end
    endtask

    task automatic test_error;
        int a0, e0;
        a0 = acc_cnt;
        e0 = err_cnt;
        send_str("R40G\r", 0);
        repeat (3) @(negedge clk);
        total++;
        if (err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL err_pulse got=%0d want=1", err_cnt - e0);
        end
        send_str("R00000001\r", 0);
        repeat (2) @(negedge clk);
        total++;
        if (acc_cnt - a0 != 1 || last_addr !== 24'h000000 || last_len !== 9'd1) begin
            bad++;
            $display("FAIL err_recover got n=%0d a=%h l=%0d want n=1 a=000000 l=1",
                     acc_cnt - a0, last_addr, last_len);
        end
        total++;
        if (err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL err_once got=%0d want=1", err_cnt - e0);
        end
    endtask

    task automatic test_slow_rx;
        int a0, r0;
        a0 = acc_cnt;
        r0 = rd_cnt;
        send_str("R0012340F\r", 1);
        repeat (2) @(negedge clk);
        total++;
        if (rd_cnt - r0 != 10) begin
            bad++;
            $display("FAIL slow_pops got=%0d want=10", rd_cnt - r0);
        end
        total++;
        if (acc_cnt - a0 != 1 || last_addr !== 24'h001234 || last_len !== 9'd15) begin
            bad++;
            $display("FAIL slow_cmd got n=%0d a=%h l=%0d want n=1 a=001234 l=15",
                     acc_cnt - a0, last_addr, last_len);
        end
    endtask

    task automatic test_reset_midline;
        int a0, e0;
        send_str("R4000", 0);
        rst = 1'b1;
        #1;
        total++;
        if ({cmd_valid, cmd_err, rx_read, echo_write, cmd_addr, cmd_len, echo_data} !== '0) begin
            bad++;
            $display("FAIL midline_reset got v=%b e=%b r=%b a=%h l=%h want all 0",
                     cmd_valid, cmd_err, rx_read, cmd_addr, cmd_len);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a0 = acc_cnt;
        e0 = err_cnt;
        send_str("R00001002\r", 0);
        repeat (2) @(negedge clk);
        total++;
        if (acc_cnt - a0 != 1 || last_addr !== 24'h000010 || last_len !== 9'd2) begin
            bad++;
            $display("FAIL midline_next got n=%0d a=%h l=%0d want n=1 a=000010 l=2",
                     acc_cnt - a0, last_addr, last_len);
        end
        total++;
        if (err_cnt != e0) begin
            bad++;
            $display("FAIL midline_no_err got=%0d want=0", err_cnt - e0);
        end
    endtask

`ifdef UART_CMD_PARSER_ECHO_EN
    task automatic test_echo;
        string s;
        int    r0, mism;
        s = "R1234560A\r";
        echo_q.delete();
        send_str("R12", 0);
        echo_ready = 1'b0;
        r0 = rd_cnt;
        rx_data  = "3";
        rx_valid = 1'b1;
        repeat (50) @(negedge clk);
        total++;
        if (rd_cnt != r0) begin
            bad++;
            $display("FAIL echo_stall got pops=%0d want=0", rd_cnt - r0);
        end
        echo_ready = 1'b1;
        send_byte("3", 0);
        send_str("4560A\r", 0);
        repeat (3) @(negedge clk);
        mism = 0;
        for (int i = 0; i < s.len() && i < echo_q.size(); i++)
            if (echo_q[i] != s[i]) mism++;
        total++;
        if (echo_q.size() != s.len() || mism != 0) begin
            bad++;
            $display("FAIL echo_order got n=%0d mism=%0d want n=%0d mism=0",
                     echo_q.size(), mism, s.len());
        end
        total++;
        if (last_addr !== 24'h123456 || last_len !== 9'd10) begin
            bad++;
            $display("FAIL echo_cmd got a=%h l=%0d want a=123456 l=10", last_addr, last_len);
        end
    endtask
`else
    task automatic test_echo;
        total++;
        if (echo_cnt != 0 || echo_data !== 8'h00) begin
            bad++;
            $display("FAIL echo_disabled got writes=%0d data=%h want 0 0", echo_cnt, echo_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_error();
        test_slow_rx();
        test_reset_midline();
        test_echo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
